// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: MIPS fetch stage holding the PC, fetching over a req/resp handshake
// and redirecting on jump, branch and JR once execute signals completion.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned WAIT_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic        instr_valid,
   input  logic        instr_done,
   input  logic        isjump,
   input  logic        isjr,
   input  logic        isbranch,
   input  logic        branch_taken,
   input  logic [31:0] jr_addr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] retired,
   output logic        fault,
   output logic [31:0] fault_pc
);
   typedef enum logic [1:0] {REQ, WAIT, ISSUE, HALT} state_t;
   state_t      state, state_nxt;
   logic [7:0]  wcnt;
   logic [31:0] next_pc;
   logic        timeout, misaligned, retire;
   assign pc_plus4   = pc + 32'd4;
   assign opcode     = instr[31:26];
   assign funct      = instr[5:0];
   assign timeout    = (wcnt + 8'd1) == 8'(WAIT_TIMEOUT);
   assign next_pc    = isjr ? jr_addr :
                       isjump ? {pc_plus4[31:28], instr[25:0], 2'b00} :
                       (isbranch && branch_taken) ? pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00} :
                       pc_plus4;
   assign misaligned = |next_pc[1:0];
   assign retire     = state == ISSUE && instr_done;
   always_ff @(posedge clk)
      if (reset) state <= REQ;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      state_nxt = state == REQ   ? (imem_ready ? WAIT : REQ) :
                  state == WAIT  ? (imem_rvalid ? ISSUE : timeout ? HALT : WAIT) :
                  state == ISSUE ? (instr_done ? (misaligned ? HALT : REQ) : ISSUE) :
                  HALT;
   end
   // imem_req is held low while reset is asserted even though reset lands in REQ
   always_comb begin
      imem_req    = state == REQ && !reset;
      imem_addr   = pc;
      instr_valid = state == ISSUE;
   end
   always_ff @(posedge clk)
      if (reset) begin
         pc       <= RESET_PC;
         instr    <= '0;
         retired  <= '0;
         fault    <= 1'b0;
         fault_pc <= '0;
         wcnt     <= '0;
      end else begin
         if (state == REQ && imem_ready) wcnt <= '0;
         if (state == WAIT) wcnt <= wcnt + 8'd1;
         if (state == WAIT && imem_rvalid) instr <= imem_rdata;
         if ((state == WAIT && !imem_rvalid && timeout) || (retire && misaligned)) begin
            fault    <= 1'b1;
            fault_pc <= pc;
         end
         if (retire) retired <= retired + 32'd1;
         if (retire && !misaligned) pc <= next_pc;
      end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the instruction-decode control block in the single-cycle MIPS datapath. Holds the PC and fetches one 32-bit instruction at a time from instruction memory over a request/response handshake. Presents the instruction, split into fields (opcode, funct, ...), to decode. Computes the next PC from the decoder's isjump/isjr/isbranch results once the instruction completes.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
WAIT_TIMEOUT, 16, max cycles in WAIT before a fetch fault (legal range 1..255).

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch byte address (= pc)
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  instruction word
instr  out  32  instruction register
opcode  out  6  instr[31:26]
funct  out  6  instr[5:0]
instr_valid  out  1  instr held and valid for decode/execute
instr_done  in  1  execute finished; sample redirect inputs
isjump  in  1  from control
isjr  in  1  from control
isbranch  in  1  from control
branch_taken  in  1  BNE condition true (ALU result nonzero)
jr_addr  in  32  register-file Da for JR
pc  out  32  address of current instruction
pc_plus4  out  32  pc + 4; link value for JAL
retired  out  32  count of completed instructions
fault  out  1  sticky: misaligned target or fetch timeout
fault_pc  out  32  pc at the time of the fault

Behaviour:
- Everything is reset synchronously when reset is high on a clk edge.
- Reset values: pc=RESET_PC; instr=0; imem_req=0; instr_valid=0; retired=0; fault=0; fault_pc=0; wait counter=0; state=REQ.
- reset has priority over every other input in the same cycle.
- Reset mid-fetch abandons the outstanding request. A late imem_rvalid arriving afterwards lands in REQ or in WAIT of the new fetch; it is ignored in REQ. The memory must drop the stale response.
- State REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_ready: go to WAIT, clear the wait counter.
  - imem_rvalid is ignored in REQ.
- State WAIT:
  - imem_req=0; the wait counter increments each cycle.
  - On imem_rvalid: instr<=imem_rdata, go to ISSUE.
  - If the counter reaches WAIT_TIMEOUT with no rvalid: fault<=1, fault_pc<=pc, go to HALT.
  - If rvalid arrives in the same cycle the counter reaches WAIT_TIMEOUT, rvalid wins.
- State ISSUE:
  - instr_valid=1; instr, opcode and funct are stable.
  - When instr_done=1: retired increments (wraps at 2^32) and next_pc is loaded into pc.
  - Then go to REQ, or to HALT on a misaligned next_pc.
  - instr_done outside ISSUE is ignored.
- next_pc priority, evaluated in ISSUE with instr_done=1:
  1. isjr: jr_addr.
  2. isjump: {pc_plus4[31:28], instr[25:0], 2'b00}.
  3. isbranch && branch_taken: pc_plus4 + (sign_extend(instr[15:0]) << 2). 32-bit arithmetic, wrap-around, no overflow detect.
  4. Otherwise: pc_plus4.
- Misaligned target (next_pc[1:0] != 0, reachable only via jr_addr):
  - pc is not updated; fault<=1, fault_pc<=pc; go to HALT.
  - retired still increments, because the JR instruction completed.
- pc_plus4 = pc + 4, combinational, wraps 32'hFFFF_FFFC -> 32'h0.
- State HALT: imem_req=0, instr_valid=0. Leaves only via reset.
- Latency: with imem_ready and imem_rvalid returned one cycle after each other, the minimum is 3 cycles per instruction: REQ, WAIT, ISSUE with instr_done in the same cycle.

Test Plan:
- Reset, then sequential fetch with 1-cycle memory and instr_done asserted on the first ISSUE cycle: addresses 0x0, 0x4, 0x8; retired=3 after the third instruction; instr_valid high exactly 1 cycle per instruction.
- J at pc=0x10 with instr[25:0]=0x40: pc becomes 0x100; the next imem_addr is 0x100.
- BNE at pc=0x20, imm=0xFFFE, branch_taken=1: pc becomes 0x1C. Same instruction with branch_taken=0: pc becomes 0x24.
- JR with jr_addr=0x200 and isjump=1 also high: pc becomes 0x200 (isjr wins).
- JR with jr_addr=0x202: fault=1, fault_pc=JR's pc, retired incremented, imem_req stays 0.
- Hold imem_rvalid low 16 cycles in WAIT: fault=1. Then reset mid-HALT: fault=0, pc=RESET_PC, imem_req=1 on the next cycle.
